// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, sync/active decode and line/frame/vblank event pulses.
// Optional frame counter output enabled by defining VTG_FRAME_COUNT_EN.
module video_timing_gen #(
   parameter int H_ACTIVE  = 1280,
   parameter int H_FP      = 110,
   parameter int H_SYNC    = 40,
   parameter int H_BP      = 220,
   parameter int V_ACTIVE  = 720,
   parameter int V_FP      = 5,
   parameter int V_SYNC    = 5,
   parameter int V_BP      = 20,
   parameter bit HSYNC_POL = 1'b1,
   parameter bit VSYNC_POL = 1'b1,
   parameter int HW        = 11,
   parameter int VW        = 10
) (
`ifdef VTG_FRAME_COUNT_EN
   output logic [15:0]   frame_cnt,
`endif
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pix_en,
   output logic          hsync,
   output logic          vsync,
   output logic          active,
   output logic [HW-1:0] x,
   output logic [VW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic          vblank_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

   // Window test done in int so sync-end bounds equal to 2^HW/2^VW cannot truncate.
   function automatic logic in_range(input int val, input int lo, input int hi);
      return (val >= lo) && (val < hi);
   endfunction

   logic [HW-1:0] h_r;
   logic [VW-1:0] v_r;
   logic [HW-1:0] h_nxt_s;
   logic [VW-1:0] v_nxt_s;

   logic          act_s;
   logic          hs_in_s;
   logic          vs_in_s;
   logic          h_zero_s;
   logic          v_zero_s;
   logic          v_vbl_s;

   logic          hsync_r;
   logic          vsync_r;
   logic          active_r;
   logic [HW-1:0] x_r;
   logic [VW-1:0] y_r;
   logic          line_start_r;
   logic          frame_start_r;
   logic          vblank_start_r;

   // Next raster position: wrap h at line end, wrap v at frame end.
   always_comb begin
      h_nxt_s = h_r;
      v_nxt_s = v_r;
      if (h_r == H_LAST) begin
         h_nxt_s = {HW{1'b0}};
         if (v_r == V_LAST) begin
            v_nxt_s = {VW{1'b0}};
         end else begin
            v_nxt_s = v_r + {{(VW-1){1'b0}}, 1'b1};
         end
      end else begin
         h_nxt_s = h_r + {{(HW-1){1'b0}}, 1'b1};
         v_nxt_s = v_r;
      end
   end

   // Decode of the current (h,v) position, registered on the advancing edge.
   always_comb begin
      act_s    = in_range(int'(h_r), 0, H_ACTIVE) && in_range(int'(v_r), 0, V_ACTIVE);
      hs_in_s  = in_range(int'(h_r), H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
      vs_in_s  = in_range(int'(v_r), V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
      h_zero_s = (h_r == {HW{1'b0}});
      v_zero_s = (v_r == {VW{1'b0}});
      v_vbl_s  = (int'(v_r) == V_ACTIVE);
   end

   // Raster counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_r <= {HW{1'b0}};
         v_r <= {VW{1'b0}};
      end else if (pix_en) begin
         h_r <= h_nxt_s;
         v_r <= v_nxt_s;
      end else begin
         h_r <= h_r;
         v_r <= v_r;
      end
   end

   // Output registers: levels hold while pix_en=0, pulses drop on every non-advancing edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_r        <= ~HSYNC_POL;
         vsync_r        <= ~VSYNC_POL;
         active_r       <= 1'b0;
         x_r            <= {HW{1'b0}};
         y_r            <= {VW{1'b0}};
         line_start_r   <= 1'b0;
         frame_start_r  <= 1'b0;
         vblank_start_r <= 1'b0;
      end else if (pix_en) begin
         hsync_r        <= hs_in_s ? HSYNC_POL : ~HSYNC_POL;
         vsync_r        <= vs_in_s ? VSYNC_POL : ~VSYNC_POL;
         active_r       <= act_s;
         x_r            <= act_s ? h_r : {HW{1'b0}};
         y_r            <= act_s ? v_r : {VW{1'b0}};
         line_start_r   <= h_zero_s;
         frame_start_r  <= h_zero_s && v_zero_s;
         vblank_start_r <= h_zero_s && v_vbl_s;
      end else begin
         line_start_r   <= 1'b0;
         frame_start_r  <= 1'b0;
         vblank_start_r <= 1'b0;
      end
   end

`ifdef VTG_FRAME_COUNT_EN
   logic [15:0] frame_cnt_r;

   // Frame counter steps on the same edge that registers frame_start high; wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_r <= 16'd0;
      end else if (pix_en && h_zero_s && v_zero_s) begin
         frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
         frame_cnt_r <= frame_cnt_r;
      end
   end

   assign frame_cnt = frame_cnt_r;
`endif

   assign hsync        = hsync_r;
   assign vsync        = vsync_r;
   assign active       = active_r;
   assign x            = x_r;
   assign y            = y_r;
   assign line_start   = line_start_r;
   assign frame_start  = frame_start_r;
   assign vblank_start = vblank_start_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen in a small 14x7 raster mode: hand-computed vector table plus
// a scoreboard reference model driven by constant, toggling and random pix_en.
module tb_video_timing_gen;

   localparam int HA = 8, HF = 2, HS = 2, HB = 2;
   localparam int VA = 4, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       act;
      logic [3:0] x;
      logic [2:0] y;
      logic       ls;
      logic       fs;
      logic       vb;
   } out_t;

   typedef struct {
      int   edge_n;
      out_t exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pix_en = 1'b0;
   logic       hsync, vsync, active, line_start, frame_start, vblank_start;
   logic [3:0] x;
   logic [2:0] y;
   logic       hsync_n, vsync_n, active_n, line_start_n, frame_start_n, vblank_start_n;
   logic [3:0] x_n;
   logic [2:0] y_n;
`ifdef VTG_FRAME_COUNT_EN
   logic [15:0] frame_cnt, frame_cnt_n;
   logic [15:0] fc_m;
`endif

   out_t dut_o;
   assign dut_o = {hsync, vsync, active, x, y, line_start, frame_start, vblank_start};

   video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .HW(4), .VW(3)
   ) dut (
`ifdef VTG_FRAME_COUNT_EN
      .frame_cnt(frame_cnt),
`endif
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
      .hsync(hsync), .vsync(vsync), .active(active), .x(x), .y(y),
      .line_start(line_start), .frame_start(frame_start), .vblank_start(vblank_start)
   );

   video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .HW(4), .VW(3)
   ) dut_neg (
`ifdef VTG_FRAME_COUNT_EN
      .frame_cnt(frame_cnt_n),
`endif
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
      .hsync(hsync_n), .vsync(vsync_n), .active(active_n), .x(x_n), .y(y_n),
      .line_start(line_start_n), .frame_start(frame_start_n), .vblank_start(vblank_start_n)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_err = 0;
   int   h_m, v_m;
   int   ncyc = 0;
   int   last_ls = -1;
   int   last_fs = -1;
   bit   period_chk = 1'b0;
   out_t exp_cur;
   out_t q[$];
   vec_t vecs[14];

   function automatic out_t mk(bit hs, bit vs, bit act, int xv, int yv, bit ls, bit fs, bit vb);
      out_t o;
      o.hs = hs; o.vs = vs; o.act = act;
      o.x = 4'(xv); o.y = 3'(yv);
      o.ls = ls; o.fs = fs; o.vb = vb;
      return o;
   endfunction

   function automatic out_t decode(int h, int v);
      bit a;
      a = (h < HA) && (v < VA);
      return mk((h >= HA + HF) && (h < HA + HF + HS),
                (v >= VA + VF) && (v < VA + VF + VS),
                a, a ? h : 0, a ? v : 0,
                h == 0, (h == 0) && (v == 0), (h == 0) && (v == VA));
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, ncyc);
      end
   endtask

   task automatic model_step(input bit pe);
      if (pe) begin
         exp_cur = decode(h_m, v_m);
`ifdef VTG_FRAME_COUNT_EN
         if (h_m == 0 && v_m == 0) fc_m = fc_m + 16'd1;
`endif
         if (h_m == HT - 1) begin
            h_m = 0;
            v_m = (v_m == VT - 1) ? 0 : v_m + 1;
         end else begin
            h_m = h_m + 1;
         end
      end else begin
         exp_cur.ls = 1'b0;
         exp_cur.fs = 1'b0;
         exp_cur.vb = 1'b0;
      end
      q.push_back(exp_cur);
   endtask

   task automatic cycle(input bit pe);
      out_t e;
      @(negedge clk);
      pix_en = pe;
      model_step(pe);
      @(posedge clk);
      #1;
      ncyc++;
      e = q.pop_front();
      check("sb_out", 32'(dut_o), 32'(e));
      check("sb_pol", {30'd0, hsync_n, vsync_n}, {30'd0, ~e.hs, ~e.vs});
`ifdef VTG_FRAME_COUNT_EN
      check("sb_fc", 32'(frame_cnt), 32'(fc_m));
`endif
      if (period_chk && dut_o.ls) begin
         if (last_ls >= 0) check("line_period", ncyc - last_ls, 2 * HT);
         last_ls = ncyc;
      end
      if (period_chk && dut_o.fs) begin
         if (last_fs >= 0) check("frame_period", ncyc - last_fs, 2 * HT * VT);
         last_fs = ncyc;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      pix_en = 1'b0;
      #1;
      check("rst_vals", 32'(dut_o), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
      check("rst_pol", {30'd0, hsync_n, vsync_n}, 32'd3);
`ifdef VTG_FRAME_COUNT_EN
      check("rst_fc", 32'(frame_cnt), 32'd0);
      fc_m = 16'd0;
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      h_m = 0;
      v_m = 0;
      exp_cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
      q.delete();
   endtask

   initial begin
      int edges;
      vecs[0]  = '{1,  mk(0, 0, 1, 0, 0, 1, 1, 0)};
      vecs[1]  = '{8,  mk(0, 0, 1, 7, 0, 0, 0, 0)};
      vecs[2]  = '{9,  mk(0, 0, 0, 0, 0, 0, 0, 0)};
      vecs[3]  = '{11, mk(1, 0, 0, 0, 0, 0, 0, 0)};
      vecs[4]  = '{12, mk(1, 0, 0, 0, 0, 0, 0, 0)};
      vecs[5]  = '{13, mk(0, 0, 0, 0, 0, 0, 0, 0)};
      vecs[6]  = '{15, mk(0, 0, 1, 0, 1, 1, 0, 0)};
      vecs[7]  = '{50, mk(0, 0, 1, 7, 3, 0, 0, 0)};
      vecs[8]  = '{57, mk(0, 0, 0, 0, 0, 1, 0, 1)};
      vecs[9]  = '{71, mk(0, 1, 0, 0, 0, 1, 0, 0)};
      vecs[10] = '{81, mk(1, 1, 0, 0, 0, 0, 0, 0)};
      vecs[11] = '{84, mk(0, 1, 0, 0, 0, 0, 0, 0)};
      vecs[12] = '{85, mk(0, 0, 0, 0, 0, 1, 0, 0)};
      vecs[13] = '{99, mk(0, 0, 1, 0, 0, 1, 1, 0)};

      apply_reset();

      // Table: pix_en held high, hand-computed outputs at chosen edges after reset.
      edges = 0;
      for (int i = 0; i < 14; i++) begin
         while (edges < vecs[i].edge_n) begin
            cycle(1'b1);
            edges++;
         end
         check($sformatf("vec%0d_edge%0d", i, vecs[i].edge_n), 32'(dut_o), 32'(vecs[i].exp));
      end
`ifdef VTG_FRAME_COUNT_EN
      check("fc_two_frames", 32'(frame_cnt), 32'd2);
`endif

      // pix_en toggling 1,0: periods double, pulses stay one clk wide.
      period_chk = 1'b1;
      repeat (2 * HT * VT + 4) begin
         cycle(1'b1);
         cycle(1'b0);
      end
      period_chk = 1'b0;

      // Random pix_en.
      repeat (600) cycle(1'($urandom_range(0, 1)));

      // Mid-line reset at (5,2), then clean restart at (0,0).
      apply_reset();
      repeat (2 * HT + 6) cycle(1'b1);
      check("pre_rst_x", 32'(x), 32'd5);
      check("pre_rst_y", 32'(y), 32'd2);
      apply_reset();
      cycle(1'b1);
      check("post_rst_fs", 32'(frame_start), 32'd1);
      check("post_rst_xy", {25'd0, x, y}, 32'd0);
      check("post_rst_act", 32'(active), 32'd1);
`ifdef VTG_FRAME_COUNT_EN
      check("fc_first", 32'(frame_cnt), 32'd1);
`endif
      repeat (HT * VT) cycle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the display path: produces horizontal/vertical sync, the active-video flag, pixel coordinates and line/frame event pulses for any CEA/VESA-style mode. It sits between the pixel clock domain and the pixel renderer (note-lane/playfield drawing) and the display encoder. Default parameters give 1280x720@60. A pixel-enable input lets one fast clock drive slower modes.

## Interface
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync pulse width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, visible lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync pulse width (lines)
- V_BP, 20, vertical back porch (lines)
- HSYNC_POL, 1, asserted level of hsync (1 = active-high)
- VSYNC_POL, 1, asserted level of vsync
- HW, 11, horizontal counter / x width; H_ACTIVE+H_FP+H_SYNC+H_BP ≤ 2^HW
- VW, 10, vertical counter / y width; V_ACTIVE+V_FP+V_SYNC+V_BP ≤ 2^VW

- clk  in  1  pixel/system clock
- rst_n  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel advance qualifier; counters and outputs update only on clk edges with pix_en=1
- hsync  out  1  horizontal sync, level per HSYNC_POL
- vsync  out  1  vertical sync, level per VSYNC_POL
- active  out  1  pixel is in visible region
- x  out  HW  horizontal pixel coordinate, 0 when active=0
- y  out  VW  vertical line coordinate, 0 when active=0
- line_start  out  1  one-clk pulse, first pixel (h=0) of every line
- frame_start  out  1  one-clk pulse, pixel (0,0)
- vblank_start  out  1  one-clk pulse, pixel (0, V_ACTIVE)
- frame_cnt  out  16  frame counter (only with VTG_FRAME_COUNT_EN)

## Operation
- Line order: active, front porch, sync, back porch. H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Internal counters h (0..H_TOTAL-1), v (0..V_TOTAL-1). On pix_en edge: h increments; at h=H_TOTAL-1, h→0 and v increments; at (H_TOTAL-1, V_TOTAL-1) both →0.
- Decode of current (h,v), registered on the same pix_en edge that advances counters:
  - active = (h < H_ACTIVE) && (v < V_ACTIVE); x = h, y = v when active, else 0.
  - hsync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), whole lines, edges aligned to h=0.
  - line_start = (h==0); frame_start = (h==0 && v==0); vblank_start = (h==0 && v==V_ACTIVE).
- Pulses are exactly one clk wide: cleared on any clk edge with pix_en=0, regardless of pixel duration.
- Level outputs (hsync, vsync, active, x, y) hold while pix_en=0.
- Counter arithmetic unsigned, widths HW/VW; no overflow permitted by parameter constraint.

## Timing
- Reset (rst_n=0, async): h=0, v=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, active=0, x=0, y=0, all pulses 0, frame_cnt=0.
- Latency: outputs for pixel (h,v) appear after the pix_en edge at which the counter held (h,v); first pix_en edge after reset presents (0,0): active=1, line_start=frame_start=1.
- Reset asserted mid-frame: all outputs return to reset values immediately; after release, restart at (0,0) — no partial-frame continuation.
- pix_en=1 constantly: one pixel per clk; frame period H_TOTAL*V_TOTAL clks.

## Configuration
- VTG_FRAME_COUNT_EN defined: frame_cnt port present; increments by 1 on the same edge frame_start is registered high (first frame after reset reads 1); wraps 0xFFFF→0x0000; reset to 0.
- Undefined: frame_cnt port and its register absent; all other behaviour identical.

## Test plan
- Defaults, pix_en=1: frame_start period 1,237,500 clks; line_start period 1650; active high 1280 clks per visible line; x runs 0..1279, y 0..719.
- Defaults: hsync asserted (1) for 40 clks starting at h=1390; vsync asserted for 5 full lines starting at v=725, h=0; vblank_start once per frame at v=720.
- Small mode (H 8/2/2/2, V 4/1/1/1), pix_en toggling 1,0: every output period doubles (line 28 clks), pulses still exactly 1 clk wide.
- HSYNC_POL=0, VSYNC_POL=0: reset values hsync=vsync=1, asserted level 0.
- Assert rst_n low mid-line at (500,300): outputs immediately at reset values; after release first pix_en edge gives frame_start=1, x=0, y=0.
- With VTG_FRAME_COUNT_EN, small mode: frame_cnt=1 after first frame_start; preload via 65,536 frames → wraps to 0.
